// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell and a borrow flop, LSB first.
// Optional SIGNED_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             bw;
    logic [CNT_W-1:0] count;

    logic             d_bit;
    logic             bo_bit;
    logic [WIDTH-1:0] r_next;

    function automatic logic cell_diff(input logic a, input logic b, input logic bi);
        return a ^ b ^ bi;
    endfunction

    function automatic logic cell_borrow(input logic a, input logic b, input logic bi);
        return (~a & b) | (~(a ^ b) & bi);
    endfunction

    // Result enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        d_bit  = cell_diff(a_sh[0], b_sh[0], bw);
        bo_bit = cell_borrow(a_sh[0], b_sh[0], bw);
        r_next = r_sh >> 1;
        r_next[WIDTH-1] = d_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            bw    <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        bw    <= Bin;
                        count <= '0;
                        r_sh  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sh  <= r_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    bw    <= bo_bit;
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        D     <= r_next;
                        Bout  <= bo_bit;
`ifdef SIGNED_OVF_EN
                        // bw here is the borrow into the MSB cell
                        ovf   <= bw ^ bo_bit;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and exhaustive bench for serial_subtractor_ctrl at WIDTH=8, 3 and 1.
// Build with SIGNED_OVF_EN defined to also check the ovf output.
module tb_serial_subtractor_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       st8 = 0, bin8 = 0, busy8, done8, bout8;
    logic [7:0] a8 = 0, b8 = 0, d8;
    logic       st3 = 0, bin3 = 0, busy3, done3, bout3;
    logic [2:0] a3 = 0, b3 = 0, d3;
    logic       st1 = 0, bin1 = 0, busy1, done1, bout1;
    logic [0:0] a1 = 0, b1 = 0, d1;
`ifdef SIGNED_OVF_EN
    logic ovf8, ovf3, ovf1;
`endif

    serial_subtractor_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8), .Bin(bin8),
        .busy(busy8), .done(done8), .D(d8), .Bout(bout8)
`ifdef SIGNED_OVF_EN
        , .ovf(ovf8)
`endif
    );
    serial_subtractor_ctrl #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .start(st3), .A(a3), .B(b3), .Bin(bin3),
        .busy(busy3), .done(done3), .D(d3), .Bout(bout3)
`ifdef SIGNED_OVF_EN
        , .ovf(ovf3)
`endif
    );
    serial_subtractor_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(st1), .A(a1), .B(b1), .Bin(bin1),
        .busy(busy1), .done(done1), .D(d1), .Bout(bout1)
`ifdef SIGNED_OVF_EN
        , .ovf(ovf1)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait8(output int bc, output bit got);
        bc = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (done8) begin
                got = 1;
                break;
            end
            if (busy8) bc++;
            @(negedge clk);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output int bc, output bit got);
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; st8 = 1;
        @(negedge clk);
        st8 = 0;
        wait8(bc, got);
    endtask

    task automatic op_small(input int w, input logic [2:0] a, input logic [2:0] b,
                            input logic bin, output int bc, output bit got);
        @(negedge clk);
        if (w == 1) begin a1 = a[0:0]; b1 = b[0:0]; bin1 = bin; st1 = 1; end
        else begin a3 = a; b3 = b; bin3 = bin; st3 = 1; end
        @(negedge clk);
        st1 = 0; st3 = 0;
        bc = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if ((w == 1) ? done1 : done3) begin
                got = 1;
                break;
            end
            if ((w == 1) ? busy1 : busy3) bc++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int  bc, nd, nb;
        bit  got;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[2] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tbl[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        tbl[5] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[8] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

        // Reset state
        #2;
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_D", 32'(d8), 0);
        chk("rst_Bout", 32'(bout8), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 9; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].bin, bc, got);
            chk($sformatf("v%0d_done", i), 32'(got), 1);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 8);
            chk($sformatf("v%0d_D", i), 32'(d8), 32'(tbl[i].d));
            chk($sformatf("v%0d_Bout", i), 32'(bout8), 32'(tbl[i].bout));
`ifdef SIGNED_OVF_EN
            chk($sformatf("v%0d_ovf", i), 32'(ovf8), 32'(tbl[i].ovf));
`endif
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(done8), 0);
            chk($sformatf("v%0d_hold_D", i), 32'(d8), 32'(tbl[i].d));
        end

        // start held high with operands changing in flight
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; bin8 = 0; st8 = 1;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1;
        wait8(bc, got);
        chk("hold_done", 32'(got), 1);
        chk("hold_busy_cycles", 32'(bc), 8);
        chk("hold_D", 32'(d8), 32'h0F);
        chk("hold_Bout", 32'(bout8), 0);
        @(negedge clk);
        st8 = 0;
        nd = 0; nb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) nd++;
            if (busy8) nb++;
        end
        chk("hold_extra_done", 32'(nd), 0);
        chk("hold_extra_busy", 32'(nb), 0);

        // back-to-back: start in the cycle right after done
        op8(8'h44, 8'h22, 1'b0, bc, got);
        chk("b2b_first_D", 32'(d8), 32'h22);
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h05; bin8 = 1; st8 = 1;
        @(negedge clk);
        st8 = 0;
        chk("b2b_busy_next", 32'(busy8), 1);
        chk("b2b_old_D_held", 32'(d8), 32'h22);
        wait8(bc, got);
        chk("b2b_done", 32'(got), 1);
        chk("b2b_D", 32'(d8), 32'hFD);
        chk("b2b_Bout", 32'(bout8), 1);

        // reset in the 4th SHIFT cycle
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; bin8 = 0; st8 = 1;
        @(negedge clk);
        st8 = 0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(busy8), 1);
        #2 rst = 1;
        #1;
        chk("abort_busy", 32'(busy8), 0);
        chk("abort_D", 32'(d8), 0);
        chk("abort_Bout", 32'(bout8), 0);
        chk("abort_done", 32'(done8), 0);
        @(negedge clk);
        rst = 0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) nd++;
        end
        chk("abort_no_done", 32'(nd), 0);
        op8(8'h33, 8'h11, 1'b0, bc, got);
        chk("after_abort_done", 32'(got), 1);
        chk("after_abort_D", 32'(d8), 32'h22);
        chk("after_abort_Bout", 32'(bout8), 0);

        // Exhaustive sweep for WIDTH=3 and WIDTH=1 against an arithmetic model
        foreach (tbl[k]) begin end
        for (int w = 1; w <= 3; w += 2) begin
            for (int a = 0; a < (1 << w); a++) begin
                for (int b = 0; b < (1 << w); b++) begin
                    for (int bi = 0; bi < 2; bi++) begin
                        int          diff, sa, sb, s, mask, half;
                        logic [31:0] act_d, act_bo, act_ovf;
                        mask = (1 << w) - 1;
                        half = 1 << (w - 1);
                        diff = a - b - bi;
                        sa = (a >= half) ? a - (1 << w) : a;
                        sb = (b >= half) ? b - (1 << w) : b;
                        s = sa - sb - bi;
                        op_small(w, 3'(a), 3'(b), 1'(bi), bc, got);
                        act_d   = (w == 1) ? 32'(d1) : 32'(d3);
                        act_bo  = (w == 1) ? 32'(bout1) : 32'(bout3);
`ifdef SIGNED_OVF_EN
                        act_ovf = (w == 1) ? 32'(ovf1) : 32'(ovf3);
                        chk($sformatf("w%0d_%0d_%0d_%0d_ovf", w, a, b, bi), act_ovf,
                            32'((s < -half) || (s > half - 1)));
`else
                        act_ovf = 0;
`endif
                        chk($sformatf("w%0d_%0d_%0d_%0d_done", w, a, b, bi), 32'(got), 1);
                        chk($sformatf("w%0d_%0d_%0d_%0d_busy", w, a, b, bi), 32'(bc), 32'(w));
                        chk($sformatf("w%0d_%0d_%0d_%0d_D", w, a, b, bi), act_d, 32'(diff & mask));
                        chk($sformatf("w%0d_%0d_%0d_%0d_Bout", w, a, b, bi), act_bo, 32'(diff < 0));
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
